// File: rtl/mem_exec_pkg.sv
// Shared types for the memory execution unit: operation codes and FSM states.
package mem_exec_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_MOVE  = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_store_queue.sv
// Circular store queue holding {addr,data} pairs awaiting the memory write port.
// With MEM_EXEC_FWD_EN defined it also compares a lookup address against every
// live entry and returns the data of the youngest match; otherwise no
// comparators exist and the match outputs are tied off.
module mem_store_queue
    import mem_exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] match_addr,
    output logic [DEPTH-1:0]  match_vec,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for entries, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage is not reset; only pointers and occupancy decide liveness.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef MEM_EXEC_FWD_EN
    // An entry matches when it is live (its age is below the occupancy) and its address equals the lookup.
    always_comb begin
        logic [PTR_W-1:0] age;
        match_vec = '0;
        age       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age          = PTR_W'(i) - rd_ptr_q;
            match_vec[i] = ({1'b0, age} < count_q) && (addr_q[i] == match_addr);
        end
    end

    // Walk oldest to youngest so the last hit seen is the youngest store.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (match_vec[idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
`else
    logic unused_match_addr;
    assign unused_match_addr = ^match_addr;
    assign match_vec = '0;
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
`endif

endmodule

// File: rtl/mem_exec_unit.sv
// Memory execution unit: accepts NOP/LOAD/STORE/MOVE, buffers stores in a
// queue that drains to the write port independently of the FSM, and services
// loads through the read port. Optional store-to-load forwarding is enabled by
// defining MEM_EXEC_FWD_EN; without it every load waits for the queue to drain.
module mem_exec_unit
    import mem_exec_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SQ_DEPTH = 4,
    localparam int CNT_W   = $clog2(SQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  mem_op_t           issue_op,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] offset,
    input  logic [DATA_W-1:0] wdata,
    output logic              completed,
    output logic [DATA_W-1:0] out,
    output logic [ADDR_W-1:0] main_mem_in_addr,
    output logic [DATA_W-1:0] main_mem_in_data,
    output logic              main_mem_in_valid,
    input  logic              main_mem_in_ready,
    output logic [ADDR_W-1:0] main_mem_out_addr,
    output logic              main_mem_out_valid,
    input  logic [DATA_W-1:0] main_mem_out_data,
    input  logic              main_mem_out_ready,
    output logic [CNT_W-1:0]  sq_count
);

    localparam logic [CNT_W-1:0] SQ_FULL = CNT_W'(SQ_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              completed_q, completed_d;

    logic [ADDR_W-1:0] eff_addr;
    logic              issue_fire, sq_push, sq_pop;
    logic [SQ_DEPTH-1:0] match_vec;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Carry out of the address add is dropped.
    assign eff_addr   = base + offset;
    assign issue_ready = !reset && (state_q == S_IDLE) &&
                         ((issue_op != OP_STORE) || (sq_count < SQ_FULL));
    assign issue_fire = issue_valid && issue_ready;

    // Write port follows the queue head only; valids are masked during reset
    // so nothing is handed to memory in the cycle the queue is being flushed.
    assign main_mem_in_valid  = (sq_count != '0) && !reset;
    assign sq_pop             = main_mem_in_valid && main_mem_in_ready;
    assign main_mem_out_valid = (state_q == S_LOAD) && !reset;
    assign main_mem_out_addr  = ld_addr_q;
    assign completed          = completed_q;
    assign out                = out_q;

    mem_store_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (SQ_DEPTH)
    ) u_sq (
        .clk        (clk),
        .reset      (reset),
        .push       (sq_push),
        .push_addr  (eff_addr),
        .push_data  (wdata),
        .pop        (sq_pop),
        .head_addr  (main_mem_in_addr),
        .head_data  (main_mem_in_data),
        .count      (sq_count),
        .match_addr (eff_addr),
        .match_vec  (match_vec),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    logic unused_match_vec;
    assign unused_match_vec = ^match_vec;
`ifndef MEM_EXEC_FWD_EN
    logic unused_fwd;
    assign unused_fwd = fwd_hit ^ (^fwd_data);
`endif

    // Next-state, result and completion logic for the operation FSM.
    always_comb begin
        state_d     = state_q;
        ld_addr_d   = ld_addr_q;
        out_d       = out_q;
        completed_d = 1'b0;
        sq_push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue_fire) begin
                    case (issue_op)
                        OP_STORE: begin
                            sq_push     = 1'b1;
                            completed_d = 1'b1;
                        end
                        OP_MOVE: begin
                            out_d       = wdata;
                            completed_d = 1'b1;
                        end
                        OP_LOAD: begin
                            ld_addr_d = eff_addr;
`ifdef MEM_EXEC_FWD_EN
                            if (fwd_hit) begin
                                out_d       = fwd_data;
                                completed_d = 1'b1;
                            end else begin
                                state_d = S_LOAD;
                            end
`else
                            state_d = S_DRAIN;
`endif
                        end
                        default: completed_d = 1'b1;
                    endcase
                end
            end
            S_DRAIN: begin
                if (sq_count == '0) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (main_mem_out_ready) begin
                    out_d       = main_mem_out_data;
                    completed_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched load address, result and completion registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ld_addr_q   <= '0;
            out_q       <= '0;
            completed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_addr_q   <= ld_addr_d;
            out_q       <= out_d;
            completed_q <= completed_d;
        end
    end

endmodule

// File: tb/tb_mem_exec_unit.sv
// Scoreboard bench for mem_exec_unit. The reference model treats memory as an
// architectural array updated in program order; writes, completions and read
// counts are checked by an independent monitor. Honours MEM_EXEC_FWD_EN.
module tb_mem_exec_unit;
    import mem_exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    mem_op_t     issue_op = OP_NOP;
    logic [31:0] base = '0, offset = '0, wdata = '0;
    logic        completed;
    logic [31:0] out;
    logic [31:0] main_mem_in_addr, main_mem_in_data;
    logic        main_mem_in_valid;
    logic        main_mem_in_ready = 1'b0;
    logic [31:0] main_mem_out_addr;
    logic        main_mem_out_valid;
    logic [31:0] main_mem_out_data = '0;
    logic        main_mem_out_ready = 1'b0;
    logic [2:0]  sq_count;

    mem_exec_unit #(.DATA_W(32), .ADDR_W(32), .SQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .base(base), .offset(offset), .wdata(wdata),
        .completed(completed), .out(out),
        .main_mem_in_addr(main_mem_in_addr), .main_mem_in_data(main_mem_in_data),
        .main_mem_in_valid(main_mem_in_valid), .main_mem_in_ready(main_mem_in_ready),
        .main_mem_out_addr(main_mem_out_addr), .main_mem_out_valid(main_mem_out_valid),
        .main_mem_out_data(main_mem_out_data), .main_mem_out_ready(main_mem_out_ready),
        .sq_count(sq_count)
    );

    always #5 clk = ~clk;

`ifdef MEM_EXEC_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_cpl[$];
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] arch [logic [31:0]];
    logic [31:0] model_out = '0;
    int          exp_rd = 0, rd_cnt = 0;
    int          n_cmp = 0, n_bad = 0;
    int          in_mode = 1, out_mode = 1;  // 0: hold low, 1: always ready, 2: random

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory model: ready generation and read data from the written array.
    always begin
        @(posedge clk);
        #2;
        main_mem_in_ready  = (in_mode == 2)  ? 1'($urandom_range(0, 1)) : (in_mode == 1);
        main_mem_out_ready = (out_mode == 2) ? 1'($urandom_range(0, 1)) : (out_mode == 1);
        main_mem_out_data  = mem.exists(main_mem_out_addr) ? mem[main_mem_out_addr]
                                                           : dflt(main_mem_out_addr);
    end

    // Monitor: every handshake/completion that the next edge will take is checked here.
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            if (main_mem_in_valid && main_mem_in_ready) begin
                chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(main_mem_in_addr), 64'(e.a));
                    chk("wr_data", 64'(main_mem_in_data), 64'(e.d));
                end
                mem[main_mem_in_addr] = main_mem_in_data;
            end
            if (main_mem_out_valid && main_mem_out_ready) begin
                rd_cnt++;
`ifndef MEM_EXEC_FWD_EN
                chk("rd_after_drain", 64'(sq_count), 64'd0);
`endif
            end
            if (completed) begin
                chk("cpl_expected", 64'(exp_cpl.size() != 0), 64'd1);
                if (exp_cpl.size() != 0) chk("cpl_out", 64'(out), 64'(exp_cpl.pop_front()));
            end
        end
    end

    // Drive one operation, wait up to lim cycles for acceptance, update the model.
    task automatic do_op(input mem_op_t op, input logic [31:0] b, input logic [31:0] o,
                         input logic [31:0] w, input int lim, output bit acc);
        logic [31:0] a, v;
        bit hit;
        a = b + o;
        v = '0;
        hit = 1'b0;
        acc = 1'b0;
        issue_valid = 1'b1; issue_op = op; base = b; offset = o; wdata = w;
        for (int i = 0; i < lim && !acc; i++) begin
            @(negedge clk);
            if (issue_ready) begin
                acc = 1'b1;
                foreach (exp_wr[k]) if (exp_wr[k].a == a) hit = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        if (acc) begin
            case (op)
                OP_STORE: begin arch[a] = w; exp_wr.push_back('{a: a, d: w}); end
                OP_MOVE:  model_out = w;
                OP_LOAD: begin
                    model_out = arch.exists(a) ? arch[a] : dflt(a);
                    if (!(FWD && hit)) exp_rd++;
                end
                default: ;
            endcase
            exp_cpl.push_back(model_out);
            if (op != OP_LOAD || (FWD && hit)) begin
                @(negedge clk);
                chk("cpl_latency", 64'(completed), 64'd1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic op(input mem_op_t o_, input logic [31:0] b, input logic [31:0] o,
                      input logic [31:0] w);
        bit acc;
        do_op(o_, b, o, w, 500, acc);
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && (exp_wr.size() != 0 || exp_cpl.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("drain_wr_left", 64'(exp_wr.size()), 64'd0);
        chk("drain_cpl_left", 64'(exp_cpl.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int rd_snap;
        // Reset behaviour.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_reset", 64'(issue_ready), 64'd0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("rst_completed", 64'(completed), 64'd0);
        chk("rst_in_valid", 64'(main_mem_in_valid), 64'd0);
        chk("rst_out_valid", 64'(main_mem_out_valid), 64'd0);
        chk("rst_sq_count", 64'(sq_count), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_ready", 64'(issue_ready), 64'd1);
        @(posedge clk); #1;

        // Single store to 0x104, MOVE, address wrap.
        op(OP_STORE, 32'h100, 32'h4, 32'hDEAD_BEEF);
        op(OP_MOVE, 32'h0, 32'h0, 32'h5);
        op(OP_STORE, 32'hFFFF_FFFC, 32'h8, 32'h1234_5678);
        op(OP_NOP, 32'h0, 32'h0, 32'h0);
        op(OP_LOAD, 32'h4, 32'h0, 32'h0);
        wait_drain();

        // Fill the queue with the write port stalled; the fifth store must be refused.
        in_mode = 0;
        for (int i = 0; i < 4; i++) op(OP_STORE, 32'h40, 32'(i * 4), 32'hA000 + 32'(i));
        do_op(OP_STORE, 32'h50, 32'h0, 32'hBAD, 4, acc);
        chk("fifth_store_blocked", 64'(acc), 64'd0);
        chk("sq_full", 64'(sq_count), 64'd4);
        @(negedge clk);
        chk("ready_low_when_full", 64'(issue_ready), 64'd0);
        @(posedge clk); #1;
        in_mode = 1;
        wait_drain();

        // Two stores to one address held in the queue, then a load of it.
        in_mode = 0;
        op(OP_STORE, 32'h200, 32'h0, 32'h11);
        op(OP_STORE, 32'h200, 32'h0, 32'h22);
        rd_snap = rd_cnt;
        op(OP_LOAD, 32'h1F0, 32'h10, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("no_read_while_queued", 64'(rd_cnt), 64'(rd_snap));
        in_mode = 1;
        wait_drain();
        chk("load_0x200_out", 64'(out), 64'h22);
        chk("read_count", 64'(rd_cnt), 64'(exp_rd));

        // Randomised mix against the model.
        in_mode = 2; out_mode = 2;
        for (int n = 0; n < 300; n++) begin
            op(mem_op_t'($urandom_range(0, 3)), 32'($urandom_range(0, 7)) << 2,
               32'h300, $urandom);
        end
        wait_drain();
        chk("read_count_rand", 64'(rd_cnt), 64'(exp_rd));

        // Reset while a load is pending behind three stalled stores.
        in_mode = 0; out_mode = 0;
        for (int i = 0; i < 3; i++) op(OP_STORE, 32'h300, 32'(i * 4), 32'h77 + 32'(i));
        op(OP_LOAD, 32'h400, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("pending_read_count", 64'(rd_cnt), 64'(exp_rd - 1));
        reset = 1'b1;
        @(negedge clk);
        chk("rdy_in_mid_reset", 64'(issue_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_wr.delete(); exp_cpl.delete();
        arch = mem; model_out = '0; exp_rd = rd_cnt;
        @(negedge clk);
        chk("mr_in_valid", 64'(main_mem_in_valid), 64'd0);
        chk("mr_out_valid", 64'(main_mem_out_valid), 64'd0);
        chk("mr_sq_count", 64'(sq_count), 64'd0);
        chk("mr_out", 64'(out), 64'd0);
        chk("mr_idle_ready", 64'(issue_ready), 64'd1);
        @(posedge clk); #1;
        in_mode = 1; out_mode = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_write_after_reset", 64'(main_mem_in_valid), 64'd0);
        op(OP_LOAD, 32'h300, 32'h0, 32'h0);
        op(OP_MOVE, 32'h0, 32'h0, 32'h99);
        wait_drain();
        chk("read_count_final", 64'(rd_cnt), 64'(exp_rd));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
